uart_bus_bridge: RTL and testbench
==================================

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter address_width, default 16, bus address width.
REQ-002 SHALL have parameter data_width, default 32, bus data width (multiple of 8).
REQ-003 SHALL have parameter ReadLatency, default 1, cycles from bus_re_o to valid bus_rdata_i (1..4).
REQ-004 SHALL have parameter TimeoutCycles, default 400000, maximum idle cycles between bytes of one frame.
REQ-005 SHALL have port clk_i  in  1  the single clock.
REQ-006 SHALL have port reset_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port rx_data_i  in  8  received byte from the UART receiver.
REQ-008 SHALL have port rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
REQ-009 SHALL have port tx_data_o  out  8  response byte to the UART transmitter.
REQ-010 SHALL have port tx_valid_o  out  1  tx_data_o valid; held until accepted.
REQ-011 SHALL have port tx_ready_i  in  1  the transmitter accepts a byte when tx_valid_o and tx_ready_i are both high.
REQ-012 SHALL have port bus_addr_o  out  address_width  bus address.
REQ-013 SHALL have port bus_wdata_o  out  data_width  bus write data.
REQ-014 SHALL have port bus_we_o  out  1  one-cycle write strobe.
REQ-015 SHALL have port bus_re_o  out  1  one-cycle read strobe.
REQ-016 SHALL have port bus_rdata_i  in  data_width  read data, sampled ReadLatency cycles after bus_re_o.
REQ-017 SHALL have port drop_o  out  1  one-cycle pulse when a received byte is discarded.

Function
REQ-018 SHALL run the states IDLE, ADDR, DATA, EXEC, WAIT_RD and RESP.
REQ-019 SHALL define these frames: write = 0x57, address bytes MSB first, data bytes MSB first; read = 0x52, address bytes MSB first.
REQ-020 SHALL, in IDLE on receiving 0x57 or 0x52, latch the opcode and go to ADDR.
REQ-021 SHALL, in IDLE on receiving any other byte, queue a single 0x15 (NAK) and go to RESP.
REQ-022 SHALL, in ADDR, shift in address_width/8 bytes; the last byte goes to DATA for a write and to EXEC for a read.
REQ-023 SHALL, in DATA, shift in data_width/8 bytes; the last byte goes to EXEC.
REQ-024 SHALL, in EXEC for a write, assert bus_we_o for exactly one cycle with bus_addr_o/bus_wdata_o stable, queue 0x06 (ACK) and go to RESP.
REQ-025 SHALL, in EXEC for a read, assert bus_re_o for exactly one cycle and go to WAIT_RD.
REQ-026 SHALL, in WAIT_RD, capture bus_rdata_i exactly ReadLatency cycles after the bus_re_o cycle, queue data_width/8 bytes MSB first and go to RESP.
REQ-027 SHALL hold bus_addr_o and bus_wdata_o at their last values between transactions.
REQ-028 SHALL, in RESP, present each queued byte on tx_data_o with tx_valid_o high until accepted, then advance; the cycle after the final accept it returns to IDLE.
REQ-029 SHALL keep tx_data_o stable while tx_valid_o is high and tx_ready_i is low.
REQ-030 SHALL reset a timeout counter on every accepted byte in ADDR and DATA.
REQ-031 SHALL, when that counter reaches TimeoutCycles, discard the partial frame, issue no bus strobe and no response, and return to IDLE.
REQ-032 SHALL, when rx_valid_i arrives in EXEC, WAIT_RD or RESP, ignore the byte and pulse drop_o.
REQ-033 SHALL never assert bus_we_o and bus_re_o in the same cycle.
REQ-034 SHALL process at most one rx byte per cycle; an rx strobe on the transition cycle into a new state is evaluated by the old state.

Reset
REQ-035 SHALL, while reset_i is high at a clock edge, enter IDLE and clear tx_valid_o, bus_we_o, bus_re_o, drop_o, the shift registers, byte counters and timeout counter.
REQ-036 SHALL set bus_addr_o, bus_wdata_o and tx_data_o to 0 on reset.
REQ-037 SHALL, on reset mid-frame or mid-response, abandon the operation with no further strobes or tx bytes.

Verification
- Write 57 90 04 DE AD BE EF → one bus_we_o with addr 0x9004, wdata 0xDEADBEEF; tx 0x06.
- Read 52 80 00, bus_rdata_i = 0x12345678 at ReadLatency = 1 → one bus_re_o at 0x8000; tx 12 34 56 78 in order.
- Hold tx_ready_i low for 10 cycles in RESP → tx_valid_o stays high with a stable byte; no byte is lost or duplicated.
- Byte 0x41 in IDLE → tx 0x15, no bus strobe.
- Send 57 90 then silence for more than TimeoutCycles (set to 50 in the bench) → no strobe, no tx, IDLE; a following 52 00 00 completes normally.
- rx byte during RESP → drop_o pulses once and the response is unchanged.
- reset_i asserted after 57 90 04 → no bus_we_o; all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge: decodes byte-framed read/write commands from a UART
// receiver into single bus strobes and returns ACK/NAK/read-data bytes.
module uart_bus_bridge #(
  parameter int address_width = 16,
  parameter int data_width    = 32,
  parameter int ReadLatency   = 1,
  parameter int TimeoutCycles = 400000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [address_width-1:0] bus_addr_o,
  output logic [data_width-1:0]    bus_wdata_o,
  output logic                     bus_we_o,
  output logic                     bus_re_o,
  input  logic [data_width-1:0]    bus_rdata_i,
  output logic                     drop_o
);

  localparam int AddrBytes = address_width / 8;
  localparam int DataBytes = data_width / 8;
  localparam int MaxBytes  = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int CntW      = $clog2(MaxBytes + 1);
  localparam int RspW      = $clog2(DataBytes + 1);
  localparam int TmoW      = $clog2(TimeoutCycles + 1);
  localparam int RdW       = $clog2(ReadLatency + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, EXEC, WAIT_RD, RESP
  } state_e;

  state_e                   state_q, state_d;
  logic                     op_write_q, op_write_d;
  logic [address_width-1:0] addr_sh_q, addr_sh_d;
  logic [data_width-1:0]    data_sh_q, data_sh_d;
  logic [address_width-1:0] bus_addr_q, bus_addr_d;
  logic [data_width-1:0]    bus_wdata_q, bus_wdata_d;
  logic [CntW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [TmoW-1:0]          timeout_q, timeout_d;
  logic [RdW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [data_width-1:0]    resp_q, resp_d;
  logic [RspW-1:0]          resp_cnt_q, resp_cnt_d;
  logic                     drop_q, drop_d;

  logic [address_width-1:0] addr_shifted;
  logic [data_width-1:0]    data_shifted;

  assign addr_shifted = (addr_sh_q << 8) | address_width'(rx_data_i);
  assign data_shifted = (data_sh_q << 8) | data_width'(rx_data_i);

  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    byte_cnt_d  = byte_cnt_q;
    timeout_d   = '0;
    rd_cnt_d    = rd_cnt_q;
    resp_d      = resp_q;
    resp_cnt_d  = resp_cnt_q;
    drop_d      = 1'b0;

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (rx_valid_i) begin
          if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
            op_write_d = (rx_data_i == 8'h57);
            state_d    = ADDR;
          end else begin
            resp_d                   = '0;
            resp_d[data_width-1 -: 8] = 8'h15;
            resp_cnt_d               = RspW'(1);
            state_d                  = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_valid_i) begin
          addr_sh_d = addr_shifted;
          if (byte_cnt_q == CntW'(AddrBytes - 1)) begin
            byte_cnt_d = '0;
            if (op_write_q) begin
              state_d = DATA;
            end else begin
              // bus address is updated on entry so it is already stable during the strobe
              bus_addr_d = addr_shifted;
              state_d    = EXEC;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end else if (timeout_q == TmoW'(TimeoutCycles - 1)) begin
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + TmoW'(1);
        end
      end

      DATA: begin
        if (rx_valid_i) begin
          data_sh_d = data_shifted;
          if (byte_cnt_q == CntW'(DataBytes - 1)) begin
            byte_cnt_d  = '0;
            bus_addr_d  = addr_sh_q;
            bus_wdata_d = data_shifted;
            state_d     = EXEC;
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end else if (timeout_q == TmoW'(TimeoutCycles - 1)) begin
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + TmoW'(1);
        end
      end

      EXEC: begin
        drop_d   = rx_valid_i;
        rd_cnt_d = '0;
        if (op_write_q) begin
          resp_d                   = '0;
          resp_d[data_width-1 -: 8] = 8'h06;
          resp_cnt_d               = RspW'(1);
          state_d                  = RESP;
        end else begin
          state_d = WAIT_RD;
        end
      end

      WAIT_RD: begin
        drop_d = rx_valid_i;
        if (rd_cnt_q == RdW'(ReadLatency - 1)) begin
          resp_d     = bus_rdata_i;
          resp_cnt_d = RspW'(DataBytes);
          state_d    = RESP;
        end else begin
          rd_cnt_d = rd_cnt_q + RdW'(1);
        end
      end

      RESP: begin
        drop_d = rx_valid_i;
        if (tx_ready_i) begin
          if (resp_cnt_q == RspW'(1)) begin
            state_d = IDLE;
          end else begin
            resp_d     = resp_q << 8;
            resp_cnt_d = resp_cnt_q - RspW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      byte_cnt_q  <= '0;
      timeout_q   <= '0;
      rd_cnt_q    <= '0;
      resp_q      <= '0;
      resp_cnt_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      byte_cnt_q  <= byte_cnt_d;
      timeout_q   <= timeout_d;
      rd_cnt_q    <= rd_cnt_d;
      resp_q      <= resp_d;
      resp_cnt_q  <= resp_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign bus_we_o    = (state_q == EXEC) &&  op_write_q;
  assign bus_re_o    = (state_q == EXEC) && !op_write_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign tx_valid_o  = (state_q == RESP);
  assign tx_data_o   = resp_q[data_width-1 -: 8];
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: framed writes/reads, NAK, backpressure,
// drop, inter-byte timeout and mid-frame reset.
module tb_uart_bus_bridge;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_we_o;
  logic        bus_re_o;
  logic [31:0] bus_rdata_i;
  logic        drop_o;

  uart_bus_bridge #(
    .address_width(16),
    .data_width(32),
    .ReadLatency(RL),
    .TimeoutCycles(50)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o),
    .bus_re_o(bus_re_o),
    .bus_rdata_i(bus_rdata_i),
    .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          we_cnt = 0, re_cnt = 0, drop_cnt = 0, hold_viol = 0, both_cnt = 0;
  logic [15:0] we_addr = '0, re_addr = '0;
  logic [31:0] we_data = '0;
  logic [31:0] rd_val = '0;
  logic [7:0]  txq[$];
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_data = '0;
  logic [3:0]  re_hist = '0;

  // Bus/UART observer; the read-data model only presents rd_val in the
  // cycle exactly RL cycles after the read strobe.
  always @(negedge clk) begin
    if (bus_we_o) begin we_cnt++; we_addr = bus_addr_o; we_data = bus_wdata_o; end
    if (bus_re_o) begin re_cnt++; re_addr = bus_addr_o; end
    if (bus_we_o && bus_re_o) both_cnt++;
    if (drop_o) drop_cnt++;
    if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    if (hold_prev && !(tx_valid_o && tx_data_o == hold_data)) hold_viol++;
    hold_prev = tx_valid_o && !tx_ready_i;
    hold_data = tx_data_o;
    bus_rdata_i = re_hist[RL-1] ? rd_val : 32'h5A5A_5A5A;
    re_hist = {re_hist[2:0], bus_re_o};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input int limit, input string tag);
    int k = 0;
    while (txq.size() < n && k < limit) begin
      tick();
      k++;
    end
    check(tag, 64'(txq.size() >= n), 64'd1);
    repeat (3) tick();
  endtask

  logic [63:0] all_outs;
  assign all_outs = {4'b0, tx_valid_o, bus_we_o, bus_re_o, drop_o,
                     tx_data_o, bus_addr_o, bus_wdata_o};

  int we_base, re_base;

  initial begin
    reset_i    = 1'b1;
    rx_data_i  = '0;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (3) tick();
    check("reset_outs", all_outs, 64'd0);
    reset_i = 1'b0;
    tick();

    // Basic write
    txq.delete();
    send_byte(8'h57); send_byte(8'h90); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_tx(1, 20, "wr_tx_timeout");
    check("wr_we_cnt", 64'(we_cnt), 64'd1);
    check("wr_addr", 64'(we_addr), 64'h9004);
    check("wr_data", 64'(we_data), 64'hDEADBEEF);
    check("wr_re_cnt", 64'(re_cnt), 64'd0);
    check("wr_tx_cnt", 64'(txq.size()), 64'd1);
    check("wr_ack", 64'(txq[0]), 64'h06);
    check("wr_addr_hold", 64'(bus_addr_o), 64'h9004);
    check("wr_wdata_hold", 64'(bus_wdata_o), 64'hDEADBEEF);

    // Basic read
    txq.delete();
    rd_val = 32'h1234_5678;
    send_byte(8'h52); send_byte(8'h80); send_byte(8'h00);
    wait_tx(4, 30, "rd_tx_timeout");
    check("rd_re_cnt", 64'(re_cnt), 64'd1);
    check("rd_addr", 64'(re_addr), 64'h8000);
    check("rd_we_cnt", 64'(we_cnt), 64'd1);
    check("rd_tx_cnt", 64'(txq.size()), 64'd4);
    check("rd_bytes", 64'({txq[0], txq[1], txq[2], txq[3]}), 64'h12345678);
    check("rd_wdata_hold", 64'(bus_wdata_o), 64'hDEADBEEF);

    // Read with transmitter backpressure, plus an rx byte during RESP
    txq.delete();
    rd_val     = 32'hA1B2_C3D4;
    tx_ready_i = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h04);
    for (int k = 0; k < 20 && !tx_valid_o; k++) tick();
    check("bp_valid_up", 64'(tx_valid_o), 64'd1);
    repeat (10) tick();
    check("bp_valid_held", 64'(tx_valid_o), 64'd1);
    check("bp_byte_held", 64'(tx_data_o), 64'hA1);
    check("bp_none_taken", 64'(txq.size()), 64'd0);
    send_byte(8'h57);
    tick(); tick();
    check("drop_once", 64'(drop_cnt), 64'd1);
    check("drop_byte_same", 64'(tx_data_o), 64'hA1);
    tx_ready_i = 1'b1;
    wait_tx(4, 20, "bp_tx_timeout");
    repeat (5) tick();
    check("bp_tx_cnt", 64'(txq.size()), 64'd4);
    check("bp_bytes", 64'({txq[0], txq[1], txq[2], txq[3]}), 64'hA1B2C3D4);
    check("bp_stable", 64'(hold_viol), 64'd0);
    check("bp_we_cnt", 64'(we_cnt), 64'd1);
    check("bp_rd_addr", 64'(re_addr), 64'h0004);

    // Unknown opcode gets NAK
    txq.delete();
    we_base = we_cnt; re_base = re_cnt;
    send_byte(8'h41);
    wait_tx(1, 10, "nak_timeout");
    check("nak_tx_cnt", 64'(txq.size()), 64'd1);
    check("nak_byte", 64'(txq[0]), 64'h15);
    check("nak_no_strobe", 64'(we_cnt + re_cnt), 64'(we_base + re_base));

    // Inter-byte gap just under the timeout still completes
    txq.delete();
    send_byte(8'h57); send_byte(8'h00);
    repeat (40) tick();
    send_byte(8'h10); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_tx(1, 20, "gap_tx_timeout");
    check("gap_we_cnt", 64'(we_cnt), 64'(we_base + 1));
    check("gap_addr", 64'(we_addr), 64'h0010);
    check("gap_data", 64'(we_data), 64'h11223344);
    check("gap_ack", 64'(txq[0]), 64'h06);

    // Timeout discards partial frame; next frame parses from IDLE
    txq.delete();
    we_base = we_cnt; re_base = re_cnt;
    send_byte(8'h57); send_byte(8'h90);
    repeat (60) tick();
    check("to_no_strobe", 64'(we_cnt + re_cnt), 64'(we_base + re_base));
    check("to_no_tx", 64'({txq.size(), 31'b0, tx_valid_o}), 64'd0);
    rd_val = 32'h0BAD_CAFE;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_tx(4, 30, "to_rd_timeout");
    check("to_re_cnt", 64'(re_cnt), 64'(re_base + 1));
    check("to_rd_addr", 64'(re_addr), 64'h0000);
    check("to_rd_bytes", 64'({txq[0], txq[1], txq[2], txq[3]}), 64'h0BADCAFE);
    check("to_we_cnt", 64'(we_cnt), 64'(we_base));

    // Reset in the middle of a write frame
    txq.delete();
    we_base = we_cnt;
    send_byte(8'h57); send_byte(8'h90); send_byte(8'h04);
    reset_i = 1'b1;
    tick();
    check("rst_mid_outs", all_outs, 64'd0);
    reset_i = 1'b0;
    repeat (10) tick();
    check("rst_no_we", 64'(we_cnt), 64'(we_base));
    check("rst_no_tx", 64'(txq.size()), 64'd0);
    check("never_both", 64'(both_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
